// File: rtl/dma_channel_file_pkg.sv
// Shared sizing defaults, per-channel mode layout and register decode codes
// for the DMA channel file.
package dmaRegConfigPkg;

    localparam int DEF_CHANNELS     = 4;
    localparam int DEF_DATAWIDTH    = 8;
    localparam int DEF_ADDRESSWIDTH = 16;
    localparam int MODE_BITS        = 6;

    typedef struct packed {
        logic [1:0] mode;
        logic       decrement;
        logic       autoInit;
        logic [1:0] xferType;
    } chMode_t;

    // Channel field select, regAddr[1:0] when regAddr[CHW+2] is clear
    localparam logic [1:0] FLD_ADDR  = 2'b00;
    localparam logic [1:0] FLD_COUNT = 2'b01;
    localparam logic [1:0] FLD_MODE  = 2'b10;
    localparam logic [1:0] FLD_RSVD  = 2'b11;

    // Control select, regAddr[1:0] when regAddr[CHW+2] is set
    localparam logic [1:0] CTL_CMD    = 2'b00;
    localparam logic [1:0] CTL_CLRPTR = 2'b01;
    localparam logic [1:0] CTL_MCLR   = 2'b10;
    localparam logic [1:0] CTL_RSVD   = 2'b11;

endpackage

// File: rtl/dma_channel_file_if.sv
// CPU programming port plus transfer-sequencer port of the DMA channel file.
// master = CPU/sequencer side, slave = channel file.
interface dma_channel_file_if #(
    parameter int CHANNELS     = dmaRegConfigPkg::DEF_CHANNELS,
    parameter int DATAWIDTH    = dmaRegConfigPkg::DEF_DATAWIDTH,
    parameter int ADDRESSWIDTH = dmaRegConfigPkg::DEF_ADDRESSWIDTH
);
    localparam int CHW = $clog2(CHANNELS);

    logic                    programCondition;
    logic                    wrEn;
    logic                    rdEn;
    logic [CHW+2:0]          regAddr;
    logic [DATAWIDTH-1:0]    dataIn;
    logic [DATAWIDTH-1:0]    dataOut;
    logic                    dataOutValid;
    logic                    xferStep;
    logic [CHW-1:0]          xferCh;
    logic [ADDRESSWIDTH-1:0] curAddr;
    logic [CHANNELS-1:0]     tcPulse;
    logic [CHANNELS-1:0]     chActive;
    logic [DATAWIDTH-1:0]    commandReg;
    logic [CHANNELS*6-1:0]   modeReg;

    modport master (
        output programCondition, wrEn, rdEn, regAddr, dataIn, xferStep, xferCh,
        input  dataOut, dataOutValid, curAddr, tcPulse, chActive, commandReg, modeReg
    );

    modport slave (
        input  programCondition, wrEn, rdEn, regAddr, dataIn, xferStep, xferCh,
        output dataOut, dataOutValid, curAddr, tcPulse, chActive, commandReg, modeReg
    );

endinterface

// File: rtl/dma_channel_counter.sv
// One channel's base/current address and count: byte-lane load, step, TC, auto-init reload.
// tcPulse is registered (one cycle after the terminal step); clear behaves as a synchronous reset.
module dma_channel_counter import dmaRegConfigPkg::*; #(
    parameter int DATAWIDTH    = DEF_DATAWIDTH,
    parameter int ADDRESSWIDTH = DEF_ADDRESSWIDTH
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    clear,
    input  logic                    wrEn,
    input  logic                    wrCount,
    input  logic                    wrHi,
    input  logic [DATAWIDTH-1:0]    wrData,
    input  logic                    step,
    input  logic                    autoInit,
    input  logic                    decrement,
    output logic [ADDRESSWIDTH-1:0] curAddr,
    output logic [ADDRESSWIDTH-1:0] curCount,
    output logic                    tcPulse,
    output logic                    active
);

    localparam logic [ADDRESSWIDTH-1:0] ONE = ADDRESSWIDTH'(1);

    logic [ADDRESSWIDTH-1:0] baseAddr;
    logic [ADDRESSWIDTH-1:0] baseCount;
    logic [ADDRESSWIDTH-1:0] nextAddr;

    assign nextAddr = decrement ? curAddr - ONE : curAddr + ONE;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            baseAddr  <= '0;
            baseCount <= '0;
            curAddr   <= '0;
            curCount  <= '0;
            tcPulse   <= 1'b0;
            active    <= 1'b0;
        end else if (clear) begin
            baseAddr  <= '0;
            baseCount <= '0;
            curAddr   <= '0;
            curCount  <= '0;
            tcPulse   <= 1'b0;
            active    <= 1'b0;
        end else begin
            tcPulse <= 1'b0;
            if (wrEn) begin
                if (wrCount) begin
                    if (wrHi) begin
                        baseCount[ADDRESSWIDTH-1:DATAWIDTH] <= wrData;
                        curCount[ADDRESSWIDTH-1:DATAWIDTH]  <= wrData;
                        active                              <= 1'b1;
                    end else begin
                        baseCount[DATAWIDTH-1:0] <= wrData;
                        curCount[DATAWIDTH-1:0]  <= wrData;
                    end
                end else begin
                    if (wrHi) begin
                        baseAddr[ADDRESSWIDTH-1:DATAWIDTH] <= wrData;
                        curAddr[ADDRESSWIDTH-1:DATAWIDTH]  <= wrData;
                    end else begin
                        baseAddr[DATAWIDTH-1:0] <= wrData;
                        curAddr[DATAWIDTH-1:0]  <= wrData;
                    end
                end
            end else if (step && active) begin
                // Terminal count is the step taken from a count of zero
                if (curCount == '0) begin
                    tcPulse <= 1'b1;
                    if (autoInit) begin
                        curAddr  <= baseAddr;
                        curCount <= baseCount;
                    end else begin
                        curAddr  <= nextAddr;
                        curCount <= '1;
                        active   <= 1'b0;
                    end
                end else begin
                    curAddr  <= nextAddr;
                    curCount <= curCount - ONE;
                end
            end
        end
    end

endmodule

// File: rtl/dma_channel_file.sv
// DMA channel register file: byte-serial CPU decode, command/status and per-channel counters.
// Reads return one cycle after rdEn; CPU strobes honoured only while programCondition is high.
module dma_channel_file import dmaRegConfigPkg::*; #(
    parameter int CHANNELS     = DEF_CHANNELS,
    parameter int DATAWIDTH    = DEF_DATAWIDTH,
    parameter int ADDRESSWIDTH = DEF_ADDRESSWIDTH
) (
    input logic              CLK,
    input logic              RESET,
    dma_channel_file_if.slave bus
);

    localparam int CHW = $clog2(CHANNELS);

    logic                    isCtl;
    logic [CHW-1:0]          selCh;
    logic [1:0]              fld;
    logic                    cpuWr;
    logic                    cpuRd;
    logic                    ptrField;
    logic                    masterClear;
    logic                    statusRd;
    logic                    stepEn;
    logic                    ptr;
    logic [DATAWIDTH-1:0]    commandQ;
    logic [DATAWIDTH-1:0]    dataOutQ;
    logic                    dataOutValidQ;
    logic [DATAWIDTH-1:0]    rdMux;
    logic [CHANNELS-1:0]     tcFlags;
    logic [CHANNELS-1:0]     tcVec;
    logic [CHANNELS-1:0]     activeVec;
    chMode_t [CHANNELS-1:0]  modeQ;
    logic [ADDRESSWIDTH-1:0] chAddr  [CHANNELS];
    logic [ADDRESSWIDTH-1:0] chCount [CHANNELS];

    assign isCtl       = bus.regAddr[CHW+2];
    assign selCh       = bus.regAddr[CHW+1:2];
    assign fld         = bus.regAddr[1:0];
    assign cpuWr       = bus.programCondition & bus.wrEn;
    assign cpuRd       = bus.programCondition & bus.rdEn & ~bus.wrEn;
    assign ptrField    = ~isCtl & ((fld == FLD_ADDR) | (fld == FLD_COUNT));
    assign masterClear = cpuWr & isCtl & (fld == CTL_MCLR);
    assign statusRd    = cpuRd & isCtl & (fld == CTL_CMD);
    assign stepEn      = bus.xferStep & ~bus.programCondition;

    for (genvar i = 0; i < CHANNELS; i++) begin : gChannel
        dma_channel_counter #(
            .DATAWIDTH    (DATAWIDTH),
            .ADDRESSWIDTH (ADDRESSWIDTH)
        ) uCounter (
            .CLK       (CLK),
            .RESET     (RESET),
            .clear     (masterClear),
            .wrEn      (cpuWr & ptrField & (selCh == CHW'(i))),
            .wrCount   (fld == FLD_COUNT),
            .wrHi      (ptr),
            .wrData    (bus.dataIn),
            .step      (stepEn & (bus.xferCh == CHW'(i))),
            .autoInit  (modeQ[i].autoInit),
            .decrement (modeQ[i].decrement),
            .curAddr   (chAddr[i]),
            .curCount  (chCount[i]),
            .tcPulse   (tcVec[i]),
            .active    (activeVec[i])
        );
    end

    always_comb begin
        rdMux = '0;
        if (isCtl) begin
            if (fld == CTL_CMD) rdMux = DATAWIDTH'(tcFlags);
        end else begin
            case (fld)
                FLD_ADDR:  rdMux = ptr ? chAddr[selCh][ADDRESSWIDTH-1:DATAWIDTH]
                                       : chAddr[selCh][DATAWIDTH-1:0];
                FLD_COUNT: rdMux = ptr ? chCount[selCh][ADDRESSWIDTH-1:DATAWIDTH]
                                       : chCount[selCh][DATAWIDTH-1:0];
                FLD_MODE:  rdMux = DATAWIDTH'(modeQ[selCh]);
                default:   rdMux = '0;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ptr           <= 1'b0;
            commandQ      <= '0;
            tcFlags       <= '0;
            dataOutQ      <= '0;
            dataOutValidQ <= 1'b0;
            modeQ         <= '0;
        end else if (masterClear) begin
            ptr           <= 1'b0;
            commandQ      <= '0;
            tcFlags       <= '0;
            dataOutQ      <= '0;
            dataOutValidQ <= 1'b0;
            modeQ         <= '0;
        end else begin
            dataOutValidQ <= cpuRd;
            // A TC landing on the status-read edge survives the clear
            tcFlags <= (statusRd ? '0 : tcFlags) | tcVec;
            if (cpuRd) dataOutQ <= rdMux;
            if (cpuWr) begin
                if (isCtl) begin
                    if (fld == CTL_CMD)    commandQ <= bus.dataIn;
                    if (fld == CTL_CLRPTR) ptr      <= 1'b0;
                end else if (fld == FLD_MODE) begin
                    modeQ[selCh] <= chMode_t'(bus.dataIn[MODE_BITS-1:0]);
                end
            end
            if ((cpuWr | cpuRd) & ptrField) ptr <= ~ptr;
        end
    end

    assign bus.dataOut      = dataOutQ;
    assign bus.dataOutValid = dataOutValidQ;
    assign bus.curAddr      = chAddr[bus.xferCh];
    assign bus.tcPulse      = tcVec;
    assign bus.chActive     = activeVec;
    assign bus.commandReg   = commandQ;
    assign bus.modeReg      = modeQ;

endmodule

// File: tb/tb_dma_channel_file.sv
// Directed and random checks of dma_channel_file against a register-level behavioural model.
module tb_dma_channel_file;

    logic clk = 1'b0;
    logic rst = 1'b0;

    initial forever #5 clk = ~clk;

    dma_channel_file_if bus ();

    dma_channel_file dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: channel registers as plain arrays, updated per accepted operation
    logic [15:0] mBaseA [4];
    logic [15:0] mCurA  [4];
    logic [15:0] mBaseC [4];
    logic [15:0] mCurC  [4];
    logic [5:0]  mMode  [4];
    logic [3:0]  mActive, mFlags, mPend;
    logic        mPtr, mVld;
    logic [7:0]  mCmd, mDataOut;
    logic [1:0]  mCh = 2'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] chA(input logic [1:0] c, input logic [1:0] f);
        return {1'b0, c, f};
    endfunction

    function automatic logic [4:0] ctlA(input logic [1:0] f);
        return {3'b100, f};
    endfunction

    task automatic mdlReset();
        for (int i = 0; i < 4; i++) begin
            mBaseA[i] = '0; mCurA[i] = '0; mBaseC[i] = '0; mCurC[i] = '0; mMode[i] = '0;
        end
        mActive = '0; mFlags = '0; mPend = '0;
        mPtr = 1'b0; mVld = 1'b0; mCmd = '0; mDataOut = '0;
    endtask

    task automatic mdlWrite(input logic [4:0] a, input logic [7:0] d);
        int ch;
        ch = int'(a[3:2]);
        if (a[4]) begin
            if (a[1:0] == 2'd0) mCmd = d;
            else if (a[1:0] == 2'd1) mPtr = 1'b0;
            else if (a[1:0] == 2'd2) mdlReset();
        end else if (a[1:0] == 2'd0) begin
            mBaseA[ch] = mPtr ? {d, mBaseA[ch][7:0]} : {mBaseA[ch][15:8], d};
            mCurA[ch]  = mPtr ? {d, mCurA[ch][7:0]}  : {mCurA[ch][15:8], d};
            mPtr = !mPtr;
        end else if (a[1:0] == 2'd1) begin
            mBaseC[ch] = mPtr ? {d, mBaseC[ch][7:0]} : {mBaseC[ch][15:8], d};
            mCurC[ch]  = mPtr ? {d, mCurC[ch][7:0]}  : {mCurC[ch][15:8], d};
            if (mPtr) mActive[ch] = 1'b1;
            mPtr = !mPtr;
        end else if (a[1:0] == 2'd2) begin
            mMode[ch] = d[5:0];
        end
    endtask

    task automatic mdlRead(input logic [4:0] a, output logic [7:0] r);
        int ch;
        ch = int'(a[3:2]);
        r = 8'h00;
        if (a[4]) begin
            if (a[1:0] == 2'd0) begin
                r = {4'h0, mFlags};
                mFlags = '0;
            end
        end else if (a[1:0] == 2'd0 || a[1:0] == 2'd1) begin
            logic [15:0] v;
            v = (a[1:0] == 2'd0) ? mCurA[ch] : mCurC[ch];
            r = mPtr ? 8'(v / 256) : 8'(v % 256);
            mPtr = !mPtr;
        end else if (a[1:0] == 2'd2) begin
            r = {2'b00, mMode[ch]};
        end
    endtask

    task automatic mdlStep(input int ch, output logic [3:0] tc);
        int delta;
        tc = '0;
        delta = mMode[ch][3] ? 65535 : 1;
        if (mCurC[ch] == 16'd0) begin
            tc[ch] = 1'b1;
            if (mMode[ch][2]) begin
                mCurA[ch] = mBaseA[ch];
                mCurC[ch] = mBaseC[ch];
            end else begin
                mCurA[ch] = 16'((int'(mCurA[ch]) + delta) % 65536);
                mCurC[ch] = 16'hFFFF;
                mActive[ch] = 1'b0;
            end
        end else begin
            mCurA[ch] = 16'((int'(mCurA[ch]) + delta) % 65536);
            mCurC[ch] = mCurC[ch] - 16'd1;
        end
    endtask

    task automatic checkAll(input string tag);
        check({tag, ":vld"},     32'(bus.dataOutValid), 32'(mVld));
        check({tag, ":dout"},    32'(bus.dataOut),      32'(mDataOut));
        check({tag, ":tc"},      32'(bus.tcPulse),      32'(mPend));
        check({tag, ":active"},  32'(bus.chActive),     32'(mActive));
        check({tag, ":cmd"},     32'(bus.commandReg),   32'(mCmd));
        check({tag, ":mode"},    32'(bus.modeReg),      32'({mMode[3], mMode[2], mMode[1], mMode[0]}));
        check({tag, ":curaddr"}, 32'(bus.curAddr),      32'(mCurA[mCh]));
    endtask

    // One clock of stimulus, starting and ending on a falling edge
    task automatic cycle(input bit pc, input bit wr, input bit rd, input logic [4:0] a,
                         input logic [7:0] d, input bit st, input logic [1:0] ch, input string tag);
        logic [3:0] newPend;
        logic [7:0] r;
        newPend = '0;
        bus.programCondition = pc; bus.wrEn = wr; bus.rdEn = rd;
        bus.regAddr = a; bus.dataIn = d; bus.xferStep = st; bus.xferCh = ch;
        mCh  = ch;
        mVld = 1'b0;
        if (pc && wr) mdlWrite(a, d);
        else if (pc && rd) begin
            mdlRead(a, r);
            mDataOut = r;
            mVld = 1'b1;
        end
        if (st && !pc && mActive[ch]) mdlStep(int'(ch), newPend);
        mFlags = mFlags | mPend;
        mPend  = newPend;
        @(negedge clk);
        bus.wrEn = 1'b0; bus.rdEn = 1'b0; bus.xferStep = 1'b0;
        checkAll(tag);
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d, input logic [1:0] ch, input string tag);
        cycle(1'b1, 1'b1, 1'b0, a, d, 1'b0, ch, tag);
    endtask

    task automatic rd(input logic [4:0] a, input logic [1:0] ch, input string tag);
        cycle(1'b1, 1'b0, 1'b1, a, 8'h00, 1'b0, ch, tag);
    endtask

    task automatic stepCh(input logic [1:0] ch, input string tag);
        cycle(1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 1'b1, ch, tag);
    endtask

    initial begin
        bus.programCondition = 1'b0; bus.wrEn = 1'b0; bus.rdEn = 1'b0;
        bus.regAddr = '0; bus.dataIn = '0; bus.xferStep = 1'b0; bus.xferCh = '0;
        mdlReset();
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        checkAll("reset");
        rst = 1'b0;
        cycle(1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 2'd0, "idle");

        // ch1 address 0x1234, count 2, read back current address
        wr(chA(1, 0), 8'h34, 2'd1, "ch1_alo");
        wr(chA(1, 0), 8'h12, 2'd1, "ch1_ahi");
        wr(chA(1, 1), 8'h02, 2'd1, "ch1_clo");
        wr(chA(1, 1), 8'h00, 2'd1, "ch1_chi");
        check("ch1_armed", 32'(bus.chActive[1]), 32'd1);
        rd(chA(1, 0), 2'd1, "ch1_rdlo");
        check("ch1_rdlo_val", 32'(bus.dataOut), 32'h34);
        rd(chA(1, 0), 2'd1, "ch1_rdhi");
        check("ch1_rdhi_val", 32'(bus.dataOut), 32'h12);

        // ch1 incrementing, no auto-init: three steps reach TC, fourth is ignored
        wr(chA(1, 2), 8'h00, 2'd1, "ch1_mode");
        check("ch1_addr0", 32'(bus.curAddr), 32'h1234);
        stepCh(2'd1, "ch1_s1");
        check("ch1_addr1", 32'(bus.curAddr), 32'h1235);
        stepCh(2'd1, "ch1_s2");
        check("ch1_addr2", 32'(bus.curAddr), 32'h1236);
        stepCh(2'd1, "ch1_s3");
        check("ch1_addr3", 32'(bus.curAddr), 32'h1237);
        check("ch1_tc", 32'(bus.tcPulse), 32'h2);
        check("ch1_disarm", 32'(bus.chActive[1]), 32'd0);
        stepCh(2'd1, "ch1_s4");
        check("ch1_addr4", 32'(bus.curAddr), 32'h1237);
        check("ch1_tc4", 32'(bus.tcPulse), 32'h0);

        // ch2 decrement + auto-init from zero base/count
        wr(ctlA(1), 8'h00, 2'd2, "ch2_clrptr");
        wr(chA(2, 2), 8'h0C, 2'd2, "ch2_mode");
        wr(chA(2, 0), 8'h00, 2'd2, "ch2_alo");
        wr(chA(2, 0), 8'h00, 2'd2, "ch2_ahi");
        wr(chA(2, 1), 8'h00, 2'd2, "ch2_clo");
        wr(chA(2, 1), 8'h00, 2'd2, "ch2_chi");
        stepCh(2'd2, "ch2_ai");
        check("ch2_ai_tc", 32'(bus.tcPulse), 32'h4);
        check("ch2_ai_addr", 32'(bus.curAddr), 32'h0000);
        check("ch2_ai_armed", 32'(bus.chActive[2]), 32'd1);
        wr(chA(2, 2), 8'h08, 2'd2, "ch2_mode_noai");
        stepCh(2'd2, "ch2_wrap");
        check("ch2_wrap_addr", 32'(bus.curAddr), 32'hFFFF);
        check("ch2_wrap_disarm", 32'(bus.chActive[2]), 32'd0);
        rd(chA(2, 1), 2'd2, "ch2_cnt_lo");
        check("ch2_cnt_lo_val", 32'(bus.dataOut), 32'hFF);

        // Status read coinciding with a ch0 TC while ch1 TC is pending
        rd(ctlA(0), 2'd0, "st_flush");
        wr(ctlA(1), 8'h00, 2'd0, "st_clrptr");
        wr(chA(1, 1), 8'h00, 2'd1, "st_c1lo");
        wr(chA(1, 1), 8'h00, 2'd1, "st_c1hi");
        wr(chA(0, 2), 8'h00, 2'd0, "st_m0");
        wr(chA(0, 1), 8'h00, 2'd0, "st_c0lo");
        wr(chA(0, 1), 8'h00, 2'd0, "st_c0hi");
        stepCh(2'd1, "st_tc1");
        cycle(1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 2'd1, "st_idle");
        stepCh(2'd0, "st_tc0");
        rd(ctlA(0), 2'd0, "st_rd1");
        check("st_rd1_val", 32'(bus.dataOut), 32'h02);
        rd(ctlA(0), 2'd0, "st_rd2");
        check("st_rd2_val", 32'(bus.dataOut), 32'h01);
        rd(ctlA(0), 2'd0, "st_rd3");
        check("st_rd3_val", 32'(bus.dataOut), 32'h00);

        // Clearing the byte pointer re-targets the low byte
        wr(ctlA(1), 8'h00, 2'd0, "bp_clr1");
        wr(chA(0, 0), 8'h11, 2'd0, "bp_lo");
        wr(ctlA(1), 8'h00, 2'd0, "bp_clr2");
        wr(chA(0, 0), 8'hAB, 2'd0, "bp_ab");
        wr(ctlA(1), 8'h00, 2'd0, "bp_clr3");
        rd(chA(0, 0), 2'd0, "bp_rd");
        check("bp_rd_val", 32'(bus.dataOut), 32'hAB);

        // Command register, then master clear
        wr(ctlA(0), 8'h5A, 2'd0, "cmd_wr");
        check("cmd_val", 32'(bus.commandReg), 32'h5A);
        wr(ctlA(2), 8'h00, 2'd1, "mclr");
        check("mclr_cmd", 32'(bus.commandReg), 32'h0);
        check("mclr_active", 32'(bus.chActive), 32'h0);
        check("mclr_dout", 32'(bus.dataOut), 32'h0);
        check("mclr_addr", 32'(bus.curAddr), 32'h0);

        // Random traffic, biased to small values so terminal counts actually occur
        for (int n = 0; n < 400; n++) begin
            logic [4:0] a;
            logic [7:0] d;
            a = 5'($urandom_range(0, 31));
            if (a[4] && a[1:0] == 2'd2 && $urandom_range(0, 7) != 0) a[1:0] = 2'd1;
            d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 3));
            cycle($urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  a, d, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), "rand");
        end

        // Asynchronous reset landing between edges while a terminal step is presented
        wr(ctlA(1), 8'h00, 2'd3, "rt_clrptr");
        wr(chA(3, 2), 8'h00, 2'd3, "rt_mode");
        wr(chA(3, 0), 8'h77, 2'd3, "rt_alo");
        wr(chA(3, 0), 8'h00, 2'd3, "rt_ahi");
        wr(chA(3, 1), 8'h00, 2'd3, "rt_clo");
        wr(chA(3, 1), 8'h00, 2'd3, "rt_chi");
        rd(chA(3, 0), 2'd3, "rt_rd");
        wr(ctlA(0), 8'h5A, 2'd3, "rt_cmd");
        check("rt_pre_dout", 32'(bus.dataOut), 32'h77);
        bus.programCondition = 1'b0;
        bus.xferStep = 1'b1;
        bus.xferCh = 2'd3;
        #2 rst = 1'b1;
        #1;
        check("rt_dout", 32'(bus.dataOut), 32'h0);
        check("rt_vld", 32'(bus.dataOutValid), 32'h0);
        check("rt_tc", 32'(bus.tcPulse), 32'h0);
        check("rt_active", 32'(bus.chActive), 32'h0);
        check("rt_cmd0", 32'(bus.commandReg), 32'h0);
        check("rt_addr", 32'(bus.curAddr), 32'h0);
        mdlReset();
        @(negedge clk);
        rst = 1'b0;
        bus.xferStep = 1'b0;
        for (int n = 0; n < 3; n++) begin
            cycle(1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 2'd3, "rt_after");
            check("rt_no_tc", 32'(bus.tcPulse), 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
